// File: rtl/ssp_stall_ctrl_if.sv
// ssp_stall_ctrl_if: bundle of the clock-unit, requester and interrupt signals of the stall arbiter
interface ssp_stall_ctrl_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
);
  logic             phi1_i;
  logic             phi2_i;
  logic [NREQ-1:0]  req_i;
  logic [CNT_W-1:0] hold_len_i;
  logic             intr_clr_i;
  logic [NREQ-1:0]  ack_o;
  logic [1:0]       ssp_intr_o;
  logic [2:0]       intr_src_o;
  logic             busy_o;
  logic             done_o;
  modport master (
    output phi1_i, phi2_i, req_i, hold_len_i, intr_clr_i,
    input  ack_o, ssp_intr_o, intr_src_o, busy_o, done_o
  );
  modport slave (
    input  phi1_i, phi2_i, req_i, hold_len_i, intr_clr_i,
    output ack_o, ssp_intr_o, intr_src_o, busy_o, done_o
  );
endinterface

// File: rtl/ssp_stall_ctrl.sv
// ssp_stall_ctrl: round-robin stall arbiter that freezes whole phi1/phi2 frames and raises a sticky interrupt
module ssp_stall_ctrl #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
) (
  input logic            clk_i,
  input logic            clear_i,
  ssp_stall_ctrl_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ARM, STALL} state_t;
  state_t           r_state;
  logic [1:0]       r_sh;
  logic             r_locked;
  logic [CNT_W-1:0] r_cnt;
  logic [IW-1:0]    r_cur;
  logic [IW-1:0]    r_last;
  logic [NREQ-1:0]  r_ack;
  logic             r_stall;
  logic             r_intr;
  logic [2:0]       r_src;
  logic             r_busy;
  logic             r_done;
  logic [IW-1:0]    w_win;
  int               w_best;
  // round-robin pick: nearest requester above the last completed one, wrapping
  always_comb begin
    w_win = r_last;
    w_best = NREQ;
    for (int i = 0; i < NREQ; i++)
      if (bus.req_i[i] && ((i + NREQ - 1 - int'(r_last)) % NREQ) < w_best) begin
        w_win = IW'(i);
        w_best = (i + NREQ - 1 - int'(r_last)) % NREQ;
      end
  end
  // shadow frame position, resynchronised by every phi2 from the clock unit
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      r_sh <= 2'd0;
      r_locked <= 1'b0;
    end else begin
      r_sh <= bus.phi2_i ? 2'd0 : r_sh + 2'd1;
      r_locked <= r_locked | bus.phi2_i;
    end
  end
  // grant, frame-aligned stall and sticky interrupt; completion beats a concurrent clear
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_cur <= '0;
      r_last <= IW'(NREQ - 1);
      r_ack <= '0;
      r_stall <= 1'b0;
      r_intr <= 1'b0;
      r_src <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_ack <= '0;
      r_done <= 1'b0;
      if (bus.intr_clr_i && !r_done) r_intr <= 1'b0;
      case (r_state)
        IDLE:
          if (r_locked && |bus.req_i) begin
            r_ack <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
            r_cur <= w_win;
            r_cnt <= (bus.hold_len_i == '0) ? CNT_W'(1) : bus.hold_len_i;
            r_busy <= 1'b1;
            r_state <= ARM;
          end
        ARM:
          if (r_sh == 2'd0) begin
            r_stall <= 1'b1;
            r_state <= STALL;
          end
        STALL:
          if (r_sh == 2'd3 && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
          else if (r_sh == 2'd0 && r_cnt == '0) begin
            r_stall <= 1'b0;
            r_done <= 1'b1;
            r_intr <= 1'b1;
            r_src <= 3'(r_cur);
            r_last <= r_cur;
            r_busy <= 1'b0;
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.ack_o = r_ack;
  assign bus.ssp_intr_o = {r_intr, r_stall};
  assign bus.intr_src_o = r_src;
  assign bus.busy_o = r_busy;
  assign bus.done_o = r_done;
endmodule

// File: tb/tb_ssp_stall_ctrl.sv
// tb_ssp_stall_ctrl: randomized scoreboard bench with a free-running clock-unit model
module tb_ssp_stall_ctrl;
  logic clk = 1'b0;
  logic clear = 1'b0;
  logic quiet = 1'b0;
  logic [1:0] pos = 2'd2;
  int total = 0;
  int bad = 0;
  int last = 3;
  int run = 0;
  int exp_ack_q[$];
  int exp_len_q[$];
  int exp_src_q[$];
  ssp_stall_ctrl_if #(.NREQ(4), .CNT_W(8)) bus();
  ssp_stall_ctrl #(.NREQ(4), .CNT_W(8)) dut (.clk_i(clk), .clear_i(clear), .bus(bus));
  initial forever #5 clk = ~clk;
  always @(posedge clk) pos <= pos + 2'd1;
  assign bus.phi1_i = !quiet && pos == 2'd1 && !bus.ssp_intr_o[0];
  assign bus.phi2_i = !quiet && pos == 2'd3 && !bus.ssp_intr_o[0];
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int rr(input logic [3:0] r, input int l);
    for (int d = 1; d <= 4; d++)
      if (r[(l + d) % 4]) return (l + d) % 4;
    return -1;
  endfunction
  task automatic wait_ev(input bit which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = which ? bus.done_o : (bus.ack_o != 4'd0);
    end
    if (!ok) check(which ? "done_timeout" : "ack_timeout", 0, 1);
  endtask
  task automatic do_txn(input logic [3:0] rq, input int hl);
    int w;
    bit ok;
    bus.req_i = rq;
    bus.hold_len_i = 8'(hl);
    w = rr(rq, last);
    exp_ack_q.push_back(w);
    exp_len_q.push_back(4 * (hl == 0 ? 1 : hl));
    exp_src_q.push_back(w);
    last = w;
    wait_ev(1'b0, ok);
    bus.hold_len_i = 8'($urandom_range(0, 255));
    wait_ev(1'b1, ok);
  endtask
  initial forever begin
    int w;
    @(negedge clk);
    if (clear) begin
      exp_ack_q.delete();
      exp_len_q.delete();
      exp_src_q.delete();
      run = 0;
    end else begin
      if (bus.ssp_intr_o[0]) begin
        if (run == 0) check("stall_rise_pos", int'(pos), 1);
        check("busy_in_stall", int'(bus.busy_o), 1);
        run++;
      end
      if (bus.ack_o != 4'd0) begin
        if (exp_ack_q.size() == 0) check("ack_unexpected", int'(bus.ack_o), 0);
        else begin
          w = exp_ack_q.pop_front();
          check("ack_onehot", int'(bus.ack_o), 1 << w);
          check("busy_at_ack", int'(bus.busy_o), 1);
        end
      end
      if (bus.done_o) begin
        if (exp_len_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          check("stall_len", run, exp_len_q.pop_front());
          check("intr_src", int'(bus.intr_src_o), exp_src_q.pop_front());
        end
        check("intr_flag", int'(bus.ssp_intr_o[1]), 1);
        check("stall_low_at_done", int'(bus.ssp_intr_o[0]), 0);
        check("phi1_after_release", int'(bus.phi1_i), 1);
        check("busy_at_done", int'(bus.busy_o), 0);
        run = 0;
      end
    end
  end
  initial begin
    bit ok;
    int acks;
    int n;
    bus.req_i = 4'd0;
    bus.hold_len_i = 8'd1;
    bus.intr_clr_i = 1'b0;
    #2 clear = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ack", int'(bus.ack_o), 0);
    check("rst_ssp_intr", int'(bus.ssp_intr_o), 0);
    check("rst_src", int'(bus.intr_src_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_done", int'(bus.done_o), 0);
    clear = 1'b0;
    do_txn(4'b0001, 1);
    repeat (4) do_txn(4'b1011, 1);
    do_txn(4'b0100, 3);
    do_txn(4'b0100, 0);
    do_txn(4'b0010, 1);
    bus.req_i = 4'd0;
    bus.intr_clr_i = 1'b1;
    @(negedge clk);
    bus.intr_clr_i = 1'b0;
    check("intr_collide_set_wins", int'(bus.ssp_intr_o[1]), 1);
    @(negedge clk);
    bus.intr_clr_i = 1'b1;
    @(negedge clk);
    bus.intr_clr_i = 1'b0;
    check("intr_lone_clear", int'(bus.ssp_intr_o[1]), 0);
    for (int t = 0; t < 30; t++) do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 4));
    bus.req_i = 4'b0001;
    bus.hold_len_i = 8'd3;
    exp_ack_q.push_back(rr(4'b0001, last));
    wait_ev(1'b0, ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.ssp_intr_o[0];
    end
    check("stall_seen_before_clear", int'(ok), 1);
    repeat (3) @(negedge clk);
    clear = 1'b1;
    quiet = 1'b1;
    #1;
    check("clr_ack", int'(bus.ack_o), 0);
    check("clr_ssp_intr", int'(bus.ssp_intr_o), 0);
    check("clr_src", int'(bus.intr_src_o), 0);
    check("clr_busy", int'(bus.busy_o), 0);
    check("clr_done", int'(bus.done_o), 0);
    repeat (2) @(negedge clk);
    clear = 1'b0;
    last = 3;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ack_o != 4'd0) acks++;
    end
    check("unlocked_holdoff_acks", acks, 0);
    exp_ack_q.push_back(0);
    exp_len_q.push_back(12);
    exp_src_q.push_back(0);
    last = 0;
    quiet = 1'b0;
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      n++;
      ok = bus.ack_o != 4'd0;
    end
    check("relock_ack_seen", int'(ok), 1);
    check("relock_ack_pos", int'(pos), 1);
    wait_ev(1'b1, ok);
    bus.req_i = 4'd0;
    repeat (4) @(negedge clk);
    check("queues_drained", exp_ack_q.size() + exp_len_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
